bt_cmd_parser: RTL
==================

Name: bt_cmd_parser

Overview:
- Receive-side framing stage directly downstream of the UART receiver in the Bluetooth peripheral.
- Consumes the receiver's byte output (`avail` strobe plus 8-bit data) and assembles 4-byte command frames: SOF, CMD, ARG, CHK.
- Delivers validated command/argument pairs to the game logic with a single-cycle valid pulse.
- Flags malformed or stalled frames.

Parameters:
- SOF, 8'hAA, start-of-frame byte value.
- TIMEOUT, 5000000, max `clk_in` cycles allowed between consecutive bytes of one frame (100 ms at 50 MHz).
- TW, 23, width of the inter-byte timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
- clk_in  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- avail  input  1  receiver "byte available" level; may originate in the divided-clock domain.
- din  input  8  received byte; stable while avail is high.
- cmd_valid  output  1  one-cycle pulse: a frame passed checksum.
- cmd  output  8  command byte of the last valid frame.
- arg  output  8  argument byte of the last valid frame.
- frame_err  output  1  one-cycle pulse: checksum mismatch or timeout.
- busy  output  1  high while a frame is partially received.
- err_count  output  8  saturating error count (present only with BT_ERRCNT_EN).

Behaviour:
- Reset (async, active-high) clears all state: state=IDLE; cmd_valid, frame_err, busy, cmd, arg = 0; timeout counter = 0; sync flops = 0. A partial frame is discarded with no error pulse.
- Input sync:
  - avail passes through a 2-flop synchroniser (s1, s2) plus a history flop s3.
  - byte strobe = s2 & ~s3.
  - Exactly one strobe per avail rising edge, however long avail stays high.
  - din is sampled in the strobe cycle.
- FSM states: IDLE, GET_CMD, GET_ARG, GET_SUM.
  - IDLE: on a strobe with din==SOF, go to GET_CMD. Any other byte is silently ignored; no error is raised.
  - GET_CMD: on a strobe, latch the CMD byte into an internal register and go to GET_ARG. SOF is accepted as ordinary data here.
  - GET_ARG: on a strobe, latch ARG and go to GET_SUM.
  - GET_SUM: on a strobe, compute the expected checksum SOF ^ cmd_r ^ arg_r.
    - Match: update the cmd/arg outputs and pulse cmd_valid.
    - Mismatch: pulse frame_err; cmd/arg keep their previous values.
    - Either outcome returns to IDLE.
- Output timing: cmd_valid/frame_err are registered and high for exactly the one cycle after the edge that consumed the CHK strobe.
- Latency:
  - An avail rise sampled at edge N gives a strobe during cycle N+1.
  - The FSM updates at edge N+2.
  - cmd_valid is high during cycle N+2..N+3.
- Timeout:
  - The counter clears on every strobe and while in IDLE.
  - It increments every cycle in the other states.
  - On reaching TIMEOUT-1 without a strobe: pulse frame_err, go to IDLE, clear the counter.
  - If a strobe and the timeout coincide in the same cycle, the strobe wins and no error is raised.
- Output rules:
  - busy = (state != IDLE), registered.
  - cmd/arg hold their last valid values indefinitely.
  - cmd_valid and frame_err are never high in the same cycle.
- Back-to-back frames: no idle gap is required. An SOF arriving on the first strobe after returning to IDLE starts a new frame.

Optional Feature:
- Macro: BT_ERRCNT_EN.
- When defined:
  - The err_count port exists.
  - It increments by 1 on each frame_err pulse and saturates at 8'hFF.
  - It is cleared only by reset.
- When undefined:
  - The port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Good frame (TIMEOUT=100): bytes AA,10,20,9A sent with >=4 clk_in between avail edges -> one cmd_valid pulse; cmd=0x10, arg=0x20; frame_err stays 0; busy high from after AA until after 9A.
- Bad checksum: bytes AA,10,20,00 -> one frame_err pulse; cmd/arg keep prior values (0x10/0x20 after the first test, 0/0 from reset); no cmd_valid.
- Resync on junk: bytes 55,00 then AA,01,02,A9 -> junk ignored with busy=0 and no error; then cmd_valid with cmd=0x01, arg=0x02.
- Timeout and recovery (TIMEOUT=100):
  - Send AA,01, then leave avail low -> frame_err fires exactly 100 cycles after the 01 strobe; busy drops.
  - Then send AA,01,02,A9 -> accepted.
- Reset mid-frame: after AA,01, assert reset for 1 cycle, then send 02,A9 -> busy=0, no cmd_valid, no frame_err; a held-high avail produces only one strobe.
- BT_ERRCNT_EN: 300 bad-checksum frames -> err_count reads 255 and holds; reset returns it to 0.

Source files
------------

// File: rtl/bt_cmd_parser.sv
// Receive-side framing stage: assembles SOF/CMD/ARG/CHK frames from UART bytes.
// Define BT_ERRCNT_EN to add the saturating err_count output.
module bt_cmd_parser #(
    parameter logic [7:0] SOF     = 8'hAA,
    parameter int         TIMEOUT = 5000000,
    parameter int         TW      = 23
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       avail,
    input  logic [7:0] din,
    output logic       cmd_valid,
    output logic [7:0] cmd,
    output logic [7:0] arg,
    output logic       frame_err,
`ifdef BT_ERRCNT_EN
    output logic [7:0] err_count,
`endif
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, GET_CMD, GET_ARG, GET_SUM} state_t;

    state_t          state_q, state_d;
    logic            s1_q, s2_q, s3_q;
    logic            s1_d, s2_d, s3_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic [7:0]      cmd_r_q, cmd_r_d, arg_r_q, arg_r_d;
    logic [7:0]      cmd_q, cmd_d, arg_q, arg_d;
    logic            valid_q, valid_d, ferr_q, ferr_d, busy_q, busy_d;
    logic            strobe;

    // avail may come from the divided-clock domain, so it is synchronised first
    assign s1_d   = avail;
    assign s2_d   = s1_q;
    assign s3_d   = s2_q;
    assign strobe = s2_q & ~s3_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_r_d = cmd_r_q;
        arg_r_d = arg_r_q;
        cmd_d   = cmd_q;
        arg_d   = arg_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        if (state_q == IDLE || strobe) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (strobe && din == SOF) state_d = GET_CMD;
            end
            GET_CMD: begin
                if (strobe) begin
                    cmd_r_d = din;
                    state_d = GET_ARG;
                end
            end
            GET_ARG: begin
                if (strobe) begin
                    arg_r_d = din;
                    state_d = GET_SUM;
                end
            end
            GET_SUM: begin
                if (strobe) begin
                    state_d = IDLE;
                    if (din == (SOF ^ cmd_r_q ^ arg_r_q)) begin
                        cmd_d   = cmd_r_q;
                        arg_d   = arg_r_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // A strobe in the same cycle as the timeout takes priority
        if (state_q != IDLE && !strobe && cnt_q == TW'(TIMEOUT - 1)) begin
            state_d = IDLE;
            cnt_d   = '0;
            ferr_d  = 1'b1;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            cnt_q   <= '0;
            cmd_r_q <= '0;
            arg_r_q <= '0;
            cmd_q   <= '0;
            arg_q   <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            cnt_q   <= cnt_d;
            cmd_r_q <= cmd_r_d;
            arg_r_q <= arg_r_d;
            cmd_q   <= cmd_d;
            arg_q   <= arg_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    assign cmd_valid = valid_q;
    assign frame_err = ferr_q;
    assign cmd       = cmd_q;
    assign arg       = arg_q;
    assign busy      = busy_q;

`ifdef BT_ERRCNT_EN
    logic [7:0] errcnt_q, errcnt_d;

    always_comb begin
        errcnt_d = errcnt_q;
        if (ferr_d && errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) errcnt_q <= '0;
        else       errcnt_q <= errcnt_d;
    end

    assign err_count = errcnt_q;
`endif

endmodule
